// File: rtl/ch_cmd_sched.sv
//==============================================================================
// ch_cmd_sched: channel command scheduler (direct entry > up/down repeat > scan).
// Define CH_SCAN_EN to compile in the timed auto-scan mode.
// Revision: 1.0
//==============================================================================
`default_nettype none

module ch_cmd_sched #(
    parameter int NUM_CH       = 10,
    parameter int RESET_CH     = 0,
    parameter int HOLD_TICKS   = 50_000,
    parameter int REPEAT_TICKS = 20_000,
    parameter int SCAN_TICKS   = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       up,
    input  logic       down,
    input  logic       dir_valid,
    input  logic [3:0] dir_ch,
    input  logic       scan_btn,
    output logic       dir_ready,
    output logic [3:0] ch,
    output logic       ch_changed,
    output logic       bad_ch,
    output logic       scanning
);

    localparam int CNT_MAX_A = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int CNT_MAX   = (CNT_MAX_A > SCAN_TICKS) ? CNT_MAX_A : SCAN_TICKS;
    localparam int CW        = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] C_HOLD_LAST   = CW'(HOLD_TICKS - 1);
    localparam logic [CW-1:0] C_REPEAT_LAST = CW'(REPEAT_TICKS - 1);
    localparam logic [3:0]    C_LAST_CH     = 4'(NUM_CH - 1);
    localparam logic [3:0]    C_RESET_CH    = 4'(RESET_CH);

`ifdef CH_SCAN_EN
    localparam logic [CW-1:0] C_SCAN_LAST = CW'(SCAN_TICKS - 1);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PRESS  = 2'd1,
        S_REPEAT = 2'd2,
        S_SCAN   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PRESS  = 2'd1,
        S_REPEAT = 2'd2
    } state_t;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    ch_q, ch_d;
    logic          dir_q, dir_d;
    logic          up_q, down_q;
    logic          chg_q, chg_d;
    logic          bad_q, bad_d;
    logic          scanning_d;

    logic w_up_rise, w_down_rise, w_scan_rise, w_held, w_accept, w_bad;

    function automatic logic [3:0] f_step(input logic [3:0] c, input logic go_up);
        if (go_up)
            return (c == C_LAST_CH) ? 4'd0 : c + 4'd1;
        else
            return (c == 4'd0) ? C_LAST_CH : c - 4'd1;
    endfunction

    assign dir_ready   = ~rst;
    assign w_up_rise   = up & ~up_q;
    assign w_down_rise = down & ~down_q;
    assign w_held      = dir_q ? up : down;
    assign w_accept    = dir_valid & dir_ready;
    assign w_bad       = ({1'b0, dir_ch} >= 5'(NUM_CH));

`ifdef CH_SCAN_EN
    logic scan_q, scanning_q;
    assign w_scan_rise = scan_btn & ~scan_q;
    assign scanning_d  = (state_d == S_SCAN);
    assign scanning    = scanning_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_q     <= 1'b0;
            scanning_q <= 1'b0;
        end else begin
            scan_q     <= scan_btn;
            scanning_q <= scanning_d;
        end
    end
`else
    logic unused_scan;
    assign unused_scan = scan_btn;
    assign w_scan_rise = 1'b0;
    assign scanning_d  = 1'b0;
    assign scanning    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        dir_d   = dir_q;
        chg_d   = 1'b0;
        bad_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_up_rise ^ w_down_rise) begin
                    dir_d   = w_up_rise;
                    ch_d    = f_step(ch_q, w_up_rise);
                    chg_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_PRESS;
                end else if (w_scan_rise) begin
`ifdef CH_SCAN_EN
                    cnt_d   = '0;
                    state_d = S_SCAN;
`endif
                end
            end
            S_PRESS, S_REPEAT: begin
                if (!w_held) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    if (cnt_q == ((state_q == S_PRESS) ? C_HOLD_LAST : C_REPEAT_LAST)) begin
                        ch_d    = f_step(ch_q, dir_q);
                        chg_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = S_REPEAT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
`ifdef CH_SCAN_EN
            S_SCAN: begin
                // Any button edge only exits scan; it is consumed without stepping.
                if (w_scan_rise | w_up_rise | w_down_rise) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (tick) begin
                    if (cnt_q == C_SCAN_LAST) begin
                        ch_d  = f_step(ch_q, 1'b1);
                        chg_d = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // A legal direct entry overrides whatever step was computed above.
        if (w_accept) begin
            if (w_bad) begin
                bad_d = 1'b1;
            end else begin
                ch_d    = dir_ch;
                chg_d   = (dir_ch != ch_q);
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ch_q    <= C_RESET_CH;
            dir_q   <= 1'b0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            chg_q   <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            dir_q   <= dir_d;
            up_q    <= up;
            down_q  <= down;
            chg_q   <= chg_d;
            bad_q   <= bad_d;
        end
    end

    assign ch         = ch_q;
    assign ch_changed = chg_q;
    assign bad_ch     = bad_q;

endmodule

`default_nettype wire
